// File: rtl/mux_2to1.sv
// mux_2to1: parameterized 2:1 selector with a combinational output, a
// registered copy, registered select and a select-change flag.
// Optional feature: define MUX_2TO1_PARITY_EN to add out_par, the XOR
// reduction of out_q, registered alongside out_q.
module mux_2to1 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             sel,
  input  logic             ld,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q,
  output logic             sel_q,
  output logic             sel_chg
`ifdef MUX_2TO1_PARITY_EN
  ,
  output logic             out_par
`endif
);

  // Combinational select; an unknown sel yields all-X rather than a silent pick
  always_comb begin
    out = 'x;
    case (sel)
      1'b0:    out = in1;
      1'b1:    out = in2;
      default: out = 'x;
    endcase
  end

  // Registered copy of the selection, select state and one-cycle change flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q   <= '0;
      sel_q   <= 1'b0;
      sel_chg <= 1'b0;
    end else if (ld) begin
      out_q   <= out;
      sel_q   <= sel;
      sel_chg <= (sel != sel_q);
    end else begin
      sel_chg <= 1'b0;
    end
  end

`ifdef MUX_2TO1_PARITY_EN
  // Parity of the value being loaded, so it lands in the same cycle as out_q
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  out_par <= 1'b0;
    else if (ld) out_par <= ^out;
  end
`endif

endmodule

// File: tb/tb_mux_2to1.sv
// tb_mux_2to1: table-driven directed vectors plus hand-written reset and
// random sequences for mux_2to1 (WIDTH=8).
module tb_mux_2to1;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] in1, in2;
  logic         sel, ld;
  logic [W-1:0] out, out_q;
  logic         sel_q, sel_chg;
`ifdef MUX_2TO1_PARITY_EN
  logic         out_par;
`endif

  int checks   = 0;
  int failures = 0;

  mux_2to1 #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in1     (in1),
    .in2     (in2),
    .sel     (sel),
    .ld      (ld),
    .out     (out),
    .out_q   (out_q),
    .sel_q   (sel_q),
    .sel_chg (sel_chg)
`ifdef MUX_2TO1_PARITY_EN
    ,
    .out_par (out_par)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic check_par(input string nm, input logic exp);
`ifdef MUX_2TO1_PARITY_EN
    check(nm, 64'(out_par), 64'(exp));
`else
    if (exp === 1'bx) $display("unused parity expectation %s", nm);
`endif
  endtask

  typedef struct {
    logic         sel;
    logic         ld;
    logic [W-1:0] in1;
    logic [W-1:0] in2;
    logic [W-1:0] e_out;
    logic [W-1:0] e_q;
    logic         e_selq;
    logic         e_chg;
    logic         e_par;
  } vec_t;

  vec_t tbl[11];

  initial begin
    logic [W-1:0] m_q;
    logic         m_selq;
    logic [W-1:0] m_sel;

    // sel ld in1 in2 | out out_q sel_q sel_chg out_par (registered after edge)
    tbl[0]  = '{1'b0, 1'b1, 8'h3C, 8'hC3, 8'h3C, 8'h3C, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 8'h3C, 8'hC3, 8'hC3, 8'hC3, 1'b1, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 8'h3C, 8'hC3, 8'hC3, 8'hC3, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 8'hFF, 8'hC3, 8'hFF, 8'hC3, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 8'hFF, 8'hC3, 8'hFF, 8'hC3, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 8'hFF, 8'hC3, 8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 8'h00, 8'h7E, 8'h7E, 8'hFF, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 8'h00, 8'h7E, 8'h7E, 8'h7E, 1'b1, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 8'h07, 8'h00, 8'h07, 8'h07, 1'b0, 1'b1, 1'b1};
    tbl[9]  = '{1'b0, 1'b1, 8'h03, 8'h00, 8'h03, 8'h03, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 8'h03, 8'h7E, 8'h7E, 8'h7E, 1'b1, 1'b1, 1'b0};

    // Reset held: out follows inputs, registers stay cleared across edges
    rst_n = 1'b0; in1 = 8'hAA; in2 = 8'h55; sel = 1'b1; ld = 1'b1;
    #1;
    check("rst_out",    64'(out),     64'h55);
    check("rst_out_q",  64'(out_q),   64'h00);
    check("rst_sel_q",  64'(sel_q),   64'h0);
    check("rst_chg",    64'(sel_chg), 64'h0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold_out_q", 64'(out_q),   64'h00);
    check("rst_hold_sel_q", 64'(sel_q),   64'h0);
    check("rst_hold_chg",   64'(sel_chg), 64'h0);
    check_par("rst_par", 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vector table
    for (int i = 0; i < 11; i++) begin
      in1 = tbl[i].in1; in2 = tbl[i].in2; sel = tbl[i].sel; ld = tbl[i].ld;
      #1;
      check($sformatf("v%0d_out", i), 64'(out), 64'(tbl[i].e_out));
      @(posedge clk);
      #1;
      check($sformatf("v%0d_out_q", i), 64'(out_q),   64'(tbl[i].e_q));
      check($sformatf("v%0d_sel_q", i), 64'(sel_q),   64'(tbl[i].e_selq));
      check($sformatf("v%0d_chg", i),   64'(sel_chg), 64'(tbl[i].e_chg));
      check_par($sformatf("v%0d_par", i), tbl[i].e_par);
      @(negedge clk);
    end

    // Async reset between edges with out_q=7E, sel_q=1, sel_chg=1, ld=0
    ld = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_out_q", 64'(out_q),   64'h00);
    check("async_sel_q", 64'(sel_q),   64'h0);
    check("async_chg",   64'(sel_chg), 64'h0);
    check("async_out",   64'(out),     64'h7E);
    @(negedge clk);
    rst_n = 1'b1;

    // First load after reset with sel=1 raises sel_chg
    in1 = 8'h11; in2 = 8'h5A; sel = 1'b1; ld = 1'b1;
    @(posedge clk);
    #1;
    check("first_out_q", 64'(out_q),   64'h5A);
    check("first_chg",   64'(sel_chg), 64'h1);
    @(negedge clk);

    // Random: new inputs every 20 ns, reference model of the register
    m_q = 8'h5A; m_selq = 1'b1;
    for (int k = 0; k < 100; k++) begin
      in1 = W'($urandom); in2 = W'($urandom); sel = 1'($urandom_range(0, 1));
      #1;
      m_sel = sel ? in2 : in1;
      check($sformatf("rnd%0d_out", k), 64'(out), 64'(m_sel));
      @(posedge clk);
      #1;
      check($sformatf("rnd%0d_out_q", k), 64'(out_q),   64'(m_sel));
      check($sformatf("rnd%0d_chg", k),   64'(sel_chg), 64'(sel != m_selq));
      m_q = m_sel; m_selq = sel;
      @(posedge clk);
      #1;
      check($sformatf("rnd%0d_hold_q", k),   64'(out_q),   64'(m_q));
      check($sformatf("rnd%0d_hold_sel", k), 64'(sel_q),   64'(m_selq));
      check($sformatf("rnd%0d_hold_chg", k), 64'(sel_chg), 64'h0);
      check_par($sformatf("rnd%0d_par", k), ^m_q);
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux_2to1.md
Name: mux_2to1

Overview:
- Parameterized 2:1 data selector used on SUBNEG datapath operand/address paths.
- Provides a combinational selected output and a registered copy of it.
- The registered copy uses one clock and an asynchronous active-low reset.
- Registered selection state and a selection-change flag support downstream sequencing.

Parameters:
- WIDTH, 8, data width of in1, in2, out, out_q; legal range 1..64.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- in1  input  WIDTH  data input selected when sel=0.
- in2  input  WIDTH  data input selected when sel=1.
- sel  input  1  select; 0 -> in1, 1 -> in2.
- ld  input  1  load enable for registered outputs; tie to 1 for free-running register.
- out  output  WIDTH  combinational selection result.
- out_q  output  WIDTH  registered selection result.
- sel_q  output  1  registered sel.
- sel_chg  output  1  one-cycle flag: last load changed sel_q.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. Clock port is clk, reset port is rst_n.
- Combinational path:
  - out = in2 when sel=1, else in1.
  - Zero latency; no dependence on clk, rst_n or ld.
  - sel=X/Z drives out to all-X in simulation. No silent default to either input.
- Reset: rst_n low asynchronously forces out_q=0, sel_q=0, sel_chg=0 and holds them while low. Deassertion is expected to be synchronous to clk, handled by the system reset synchronizer.
- Rising clk edge with rst_n=1 and ld=1:
  - out_q <= (sel ? in2 : in1).
  - sel_q <= sel.
  - sel_chg <= (sel != sel_q).
- Rising clk edge with ld=0:
  - out_q and sel_q hold.
  - sel_chg <= 0.
- Latency: out_q and sel_q reflect inputs sampled one clk edge earlier.
- First load after reset with sel=1 sets sel_chg=1, since sel_q resets to 0.
- Simultaneous input changes: only values stable at the clk edge matter. in1/in2/sel changing together is legal.
- Reset asserted mid-operation clears registered outputs immediately, regardless of clk or ld. out continues to follow inputs combinationally.
- No internal state besides out_q, sel_q, sel_chg (and out_par when enabled).
- No arithmetic; widths pass through unchanged with no truncation or extension.

Optional Feature:
- Macro MUX_2TO1_PARITY_EN.
- When defined:
  - Adds output out_par (1 bit) = even parity (XOR reduction) of out_q, registered together with out_q.
  - out_par resets to 0 and holds when ld=0.
- When undefined: port out_par does not exist and no parity logic is built.

Test Plan:
- Reset: rst_n=0 with in1=8'hAA, in2=8'h55, sel=1 -> out=8'h55 immediately; out_q=8'h00, sel_q=0, sel_chg=0 while reset held, including across clk edges.
- Select both ways: ld=1, in1=8'h3C, in2=8'hC3. sel=0 -> out=8'h3C, next edge out_q=8'h3C. sel=1 -> out=8'hC3, next edge out_q=8'hC3, sel_chg=1 for one cycle.
- Hold: ld=0, change in1 to 8'hFF with sel=0 -> out=8'hFF immediately; out_q keeps the previous value 8'hC3 and sel_chg=0 on subsequent edges.
- Async reset mid-run: out_q=8'h7E, assert rst_n=0 between clk edges -> out_q=8'h00 without waiting for clk.
- Random: 100 iterations, in1/in2 = $urandom, sel random 0/1, 20 ns apart with 10 ns clk period. Checks:
  - out always equals the reference selection.
  - out_q equals the selection sampled at the prior edge.
- Parity (MUX_2TO1_PARITY_EN): out_q=8'h07 -> out_par=1; out_q=8'h03 -> out_par=0.
